// File: rtl/muller_c_monitor.sv
// -----------------------------------------------------------------------------
// muller_c_monitor
//
// Clocked checker for a bank of Muller C-gate test instances. Each channel's
// two gate inputs (a, b) and the gate output (c) are asynchronous. They are
// synchronised and compared against a clocked golden C-element model. A
// per-channel FSM waits for the inputs to be quiet for SETTLE_CYC cycles
// before it compares the gate output with the model. Mismatch episodes set
// sticky per-channel flags and advance a saturating event counter.
//
// Parameters:
//   NCH         number of monitored channels (1..8)
//   SYNC_STAGES synchroniser flops per asynchronous input (>=2)
//   SETTLE_CYC  quiet cycles needed after the last input change (>=1)
//   CNT_W       width of err_cnt
//
// Ports:
//   CLK_33MHZ_FPGA   in   system clock; all state changes on the rising edge
//   FPGA_CPU_RESET_B in   asynchronous active-low reset
//   a, b             in   C-gate inputs per channel (asynchronous)
//   c                in   C-gate output per channel (asynchronous)
//   clr              in   one-cycle synchronous clear of err_flag / err_cnt
//   golden           out  golden C-element value per channel
//   busy             out  channel is settling or checking
//   err_flag         out  sticky mismatch flag per channel
//   err_cnt          out  saturating count of mismatch episodes
// -----------------------------------------------------------------------------
module muller_c_monitor #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int CNT_W       = 16
) (
    input  logic             CLK_33MHZ_FPGA,
    input  logic             FPGA_CPU_RESET_B,
    input  logic [NCH-1:0]   a,
    input  logic [NCH-1:0]   b,
    input  logic [NCH-1:0]   c,
    input  logic             clr,
    output logic [NCH-1:0]   golden,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   err_flag,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int TMR_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int POP_W = $clog2(NCH + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_STABLE = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2
    } state_t;

    // Number of set bits in an event vector.
    function automatic logic [POP_W-1:0] popcount(input logic [NCH-1:0] v);
        logic [POP_W-1:0] acc;
        acc = {POP_W{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            acc = acc + POP_W'(v[k]);
        end
        return acc;
    endfunction

    logic [NCH-1:0]   sync_a_r [SYNC_STAGES];
    logic [NCH-1:0]   sync_b_r [SYNC_STAGES];
    logic [NCH-1:0]   sync_c_r [SYNC_STAGES];
    logic [NCH-1:0]   a_s;
    logic [NCH-1:0]   b_s;
    logic [NCH-1:0]   c_s;
    logic [NCH-1:0]   a_prev_r;
    logic [NCH-1:0]   b_prev_r;
    logic [NCH-1:0]   chg_s;
    logic [NCH-1:0]   chg_eff_s;
    logic             first_r;
    logic [NCH-1:0]   golden_r;
    logic [NCH-1:0]   mm_r;
    logic [NCH-1:0]   mm_nxt_s;
    logic [NCH-1:0]   cmp_s;
    logic [NCH-1:0]   ev_s;
    logic [POP_W-1:0] ev_cnt_s;
    logic [CNT_W:0]   sum_s;
    state_t           state_r [NCH];
    logic [TMR_W-1:0] timer_r [NCH];
    logic [NCH-1:0]   busy_r;
    logic [NCH-1:0]   err_flag_r;
    logic [CNT_W-1:0] err_cnt_r;

    // Synchroniser chains for the three asynchronous input buses.
    always_ff @(posedge CLK_33MHZ_FPGA or negedge FPGA_CPU_RESET_B) begin
        if (!FPGA_CPU_RESET_B) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_a_r[k] <= {NCH{1'b0}};
                sync_b_r[k] <= {NCH{1'b0}};
                sync_c_r[k] <= {NCH{1'b0}};
            end
        end else begin
            sync_a_r[0] <= a;
            sync_b_r[0] <= b;
            sync_c_r[0] <= c;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_a_r[k] <= sync_a_r[k-1];
                sync_b_r[k] <= sync_b_r[k-1];
                sync_c_r[k] <= sync_c_r[k-1];
            end
        end
    end

    assign a_s = sync_a_r[SYNC_STAGES-1];
    assign b_s = sync_b_r[SYNC_STAGES-1];
    assign c_s = sync_c_r[SYNC_STAGES-1];

    // The first cycle after reset release is treated as an input change so
    // every channel settles before its first comparison; otherwise a channel
    // whose inputs sit at 1/1 would be compared against a not-yet-updated
    // golden value of 0.
    assign chg_s     = (a_s ^ a_prev_r) | (b_s ^ b_prev_r);
    assign chg_eff_s = chg_s | {NCH{first_r}};
    assign cmp_s     = c_s ^ golden_r;

    // Previous synchronised inputs, start-up marker and golden C-element.
    always_ff @(posedge CLK_33MHZ_FPGA or negedge FPGA_CPU_RESET_B) begin
        if (!FPGA_CPU_RESET_B) begin
            a_prev_r <= {NCH{1'b0}};
            b_prev_r <= {NCH{1'b0}};
            first_r  <= 1'b1;
            golden_r <= {NCH{1'b0}};
        end else begin
            a_prev_r <= a_s;
            b_prev_r <= b_s;
            first_r  <= 1'b0;
            // Follow the inputs when they agree, hold when they differ.
            golden_r <= (a_s & b_s) | (golden_r & (a_s ^ b_s));
        end
    end

    // Next mismatch state and rising-edge mismatch events per channel.
    always_comb begin
        mm_nxt_s = {NCH{1'b0}};
        ev_s     = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            case (state_r[i])
                ST_STABLE: begin
                    if (chg_eff_s[i]) begin
                        mm_nxt_s[i] = mm_r[i];
                    end else begin
                        mm_nxt_s[i] = cmp_s[i];
                    end
                    ev_s[i] = mm_nxt_s[i] & ~mm_r[i];
                end
                ST_CHECK: begin
                    mm_nxt_s[i] = cmp_s[i];
                    ev_s[i]     = mm_nxt_s[i] & ~mm_r[i];
                end
                ST_SETTLE: begin
                    mm_nxt_s[i] = 1'b0;
                    ev_s[i]     = 1'b0;
                end
                default: begin
                    mm_nxt_s[i] = 1'b0;
                    ev_s[i]     = 1'b0;
                end
            endcase
        end
    end

    assign ev_cnt_s = popcount(ev_s);
    assign sum_s    = {1'b0, err_cnt_r} + {{(CNT_W + 1 - POP_W){1'b0}}, ev_cnt_s};

    // Per-channel settle/check FSM with registered busy and mismatch state.
    always_ff @(posedge CLK_33MHZ_FPGA or negedge FPGA_CPU_RESET_B) begin
        if (!FPGA_CPU_RESET_B) begin
            for (int i = 0; i < NCH; i++) begin
                state_r[i] <= ST_STABLE;
                timer_r[i] <= {TMR_W{1'b0}};
            end
            busy_r <= {NCH{1'b0}};
            mm_r   <= {NCH{1'b0}};
        end else begin
            mm_r <= mm_nxt_s;
            for (int i = 0; i < NCH; i++) begin
                case (state_r[i])
                    ST_STABLE: begin
                        if (chg_eff_s[i]) begin
                            state_r[i] <= ST_SETTLE;
                            timer_r[i] <= TMR_LOAD;
                            busy_r[i]  <= 1'b1;
                        end else begin
                            state_r[i] <= ST_STABLE;
                            busy_r[i]  <= 1'b0;
                        end
                    end
                    ST_SETTLE: begin
                        busy_r[i] <= 1'b1;
                        if (chg_eff_s[i]) begin
                            timer_r[i] <= TMR_LOAD;
                        end else if (timer_r[i] == {TMR_W{1'b0}}) begin
                            state_r[i] <= ST_CHECK;
                        end else begin
                            timer_r[i] <= timer_r[i] - TMR_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        if (chg_eff_s[i]) begin
                            state_r[i] <= ST_SETTLE;
                            timer_r[i] <= TMR_LOAD;
                            busy_r[i]  <= 1'b1;
                        end else begin
                            state_r[i] <= ST_STABLE;
                            busy_r[i]  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r[i] <= ST_STABLE;
                        timer_r[i] <= {TMR_W{1'b0}};
                        busy_r[i]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky error flags and saturating episode counter. A clear takes
    // effect first, so events in the clearing cycle are still recorded.
    always_ff @(posedge CLK_33MHZ_FPGA or negedge FPGA_CPU_RESET_B) begin
        if (!FPGA_CPU_RESET_B) begin
            err_flag_r <= {NCH{1'b0}};
            err_cnt_r  <= {CNT_W{1'b0}};
        end else if (clr) begin
            err_flag_r <= ev_s;
            err_cnt_r  <= CNT_W'(ev_cnt_s);
        end else begin
            err_flag_r <= err_flag_r | ev_s;
            if (sum_s[CNT_W]) begin
                err_cnt_r <= {CNT_W{1'b1}};
            end else begin
                err_cnt_r <= sum_s[CNT_W-1:0];
            end
        end
    end

    assign golden   = golden_r;
    assign busy     = busy_r;
    assign err_flag = err_flag_r;
    assign err_cnt  = err_cnt_r;

endmodule
